// File: rtl/fsm_led_multi.sv
// Multi-mode LED pattern sequencer: run-left, run-right, ping-pong and blink patterns
// advancing once every TIME_STEP clocks, with runtime mode reload and pause.
`timescale 1ns/1ps
module fsm_led_multi #(
  parameter int LED_W     = 4,
  parameter int TIME_STEP = 100_000_000,
  parameter int CNT_W     = $clog2(TIME_STEP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             mode_vld,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       cur_mode,
  output logic             step
);

  typedef enum logic [1:0] {
    RUN_LEFT  = 2'd0,
    RUN_RIGHT = 2'd1,
    PING_PONG = 2'd2,
    BLINK     = 2'd3
  } mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  mode_t            state_q;
  mode_t            state_nxt;
  logic [CNT_W-1:0] cnt_p0;
  logic             dir_p0;
  logic             tick;
  logic [LED_W-1:0] led_adv;
  logic             dir_adv;

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] rotr(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

  function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m);
    logic [LED_W-1:0] p;
    case (m)
      2'd1:    p = LED_W'(1) << (LED_W - 1);
      2'd3:    p = '1;
      default: p = LED_W'(1);
    endcase
    return p;
  endfunction

  // Mode FSM: the state is the active pattern and only moves on reload or reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN_LEFT;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (mode_vld) state_nxt = mode_t'(mode);
  end

  assign cur_mode = state_q;
  assign tick     = !pause && (cnt_p0 == CNT_W'(TIME_STEP - 1));

  always_comb begin
    led_adv = led;
    dir_adv = dir_p0;
    case (state_q)
      RUN_LEFT:  led_adv = rotl(led);
      RUN_RIGHT: led_adv = rotr(led);
      PING_PONG: begin
        // The end bit reverses and steps away on the same tick, so ends never dwell
        if (dir_p0 == DIR_LEFT) begin
          if (led[LED_W-1]) begin
            led_adv = led >> 1;
            dir_adv = DIR_RIGHT;
          end else begin
            led_adv = led << 1;
          end
        end else begin
          if (led[0]) begin
            led_adv = led << 1;
            dir_adv = DIR_LEFT;
          end else begin
            led_adv = led >> 1;
          end
        end
      end
      BLINK:     led_adv = ~led;
    endcase
  end

  // Step counter and pattern register: reload beats advance, pause freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      led    <= LED_W'(1);
      dir_p0 <= DIR_LEFT;
      step   <= 1'b0;
    end else if (mode_vld) begin
      cnt_p0 <= '0;
      led    <= init_pattern(mode);
      dir_p0 <= DIR_LEFT;
      step   <= 1'b0;
    end else if (pause) begin
      step   <= 1'b0;
    end else if (tick) begin
      cnt_p0 <= '0;
      led    <= led_adv;
      dir_p0 <= dir_adv;
      step   <= 1'b1;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
      step   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_led_multi.sv
// Directed bench for fsm_led_multi with LED_W=4, TIME_STEP=4.
`timescale 1ns/1ps
module tb_fsm_led_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       mode_vld;
  logic       pause;
  logic [3:0] led;
  logic [1:0] cur_mode;
  logic       step;

  int checks   = 0;
  int failures = 0;
  logic [3:0] last_led;

  fsm_led_multi #(.LED_W(4), .TIME_STEP(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .mode_vld(mode_vld), .pause(pause),
    .led(led), .cur_mode(cur_mode), .step(step)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three quiet cycles holding the previous pattern, then one advance with a step pulse
  task automatic adv(input string tag, input logic [3:0] exp_led);
    cyc(3);
    chk({tag, "_hold_step"}, 32'(step), 32'd0);
    chk({tag, "_hold_led"}, 32'(led), 32'(last_led));
    cyc(1);
    chk({tag, "_step"}, 32'(step), 32'd1);
    chk({tag, "_led"}, 32'(led), 32'(exp_led));
    last_led = exp_led;
  endtask

  task automatic load(input string tag, input logic [1:0] m, input logic [3:0] exp_led);
    mode = m;
    mode_vld = 1'b1;
    cyc(1);
    mode_vld = 1'b0;
    chk({tag, "_led"}, 32'(led), 32'(exp_led));
    chk({tag, "_mode"}, 32'(cur_mode), 32'(m));
    chk({tag, "_step"}, 32'(step), 32'd0);
    last_led = exp_led;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; mode_vld = 1'b0; pause = 1'b0;
    cyc(3);
    chk("rst_led", 32'(led), 32'h1);
    chk("rst_mode", 32'(cur_mode), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    rst = 1'b0;
    last_led = 4'b0001;

    adv("rl1", 4'b0010);
    adv("rl2", 4'b0100);
    adv("rl3", 4'b1000);
    adv("rl4", 4'b0001);

    load("ld_rr", 2'd1, 4'b1000);
    adv("rr1", 4'b0100);
    adv("rr2", 4'b0010);
    adv("rr3", 4'b0001);
    adv("rr4", 4'b1000);

    load("ld_pp", 2'd2, 4'b0001);
    adv("pp1", 4'b0010);
    adv("pp2", 4'b0100);
    adv("pp3", 4'b1000);
    adv("pp4", 4'b0100);
    adv("pp5", 4'b0010);
    adv("pp6", 4'b0001);
    adv("pp7", 4'b0010);

    load("ld_bl", 2'd3, 4'b1111);
    adv("bl1", 4'b0000);
    adv("bl2", 4'b1111);
    adv("bl3", 4'b0000);
    adv("bl4", 4'b1111);

    // Pause two cycles into a step; the remaining two cycles must follow the release
    cyc(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pause_led", 32'(led), 32'hF);
      chk("pause_step", 32'(step), 32'd0);
    end
    pause = 1'b0;
    cyc(1);
    chk("resume1_step", 32'(step), 32'd0);
    chk("resume1_led", 32'(led), 32'hF);
    cyc(1);
    chk("resume2_step", 32'(step), 32'd1);
    chk("resume2_led", 32'(led), 32'h0);

    // Reload on the very cycle the counter would tick
    cyc(3);
    load("ld_on_tick", 2'd0, 4'b0001);
    last_led = 4'b0001;
    adv("after_tick_ld", 4'b0010);

    // Reload while paused takes effect, then outputs hold
    pause = 1'b1;
    load("ld_paused", 2'd1, 4'b1000);
    cyc(5);
    chk("paused_hold_led", 32'(led), 32'h8);
    chk("paused_hold_step", 32'(step), 32'd0);
    pause = 1'b0;
    adv("after_pause_ld", 4'b0100);

    // Reset mid ping-pong while travelling right
    load("ld_pp2", 2'd2, 4'b0001);
    adv("pq1", 4'b0010);
    adv("pq2", 4'b0100);
    adv("pq3", 4'b1000);
    adv("pq4", 4'b0100);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_led", 32'(led), 32'h1);
    chk("midrst_mode", 32'(cur_mode), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);
    last_led = 4'b0001;
    adv("after_rst", 4'b0010);

    // Reset outranks a simultaneous mode strobe
    rst = 1'b1; mode = 2'd3; mode_vld = 1'b1;
    cyc(1);
    rst = 1'b0; mode_vld = 1'b0;
    chk("rst_vs_vld_mode", 32'(cur_mode), 32'd0);
    chk("rst_vs_vld_led", 32'(led), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
